bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters.
REQ-002 The block SHALL have parameter SELW, default 5, giving the bus-mux select width (selects r0..r31).
REQ-003 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum number of cycles one requester may own the bus.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, NREQ bits: bus request, one bit per requester.
REQ-007 The block SHALL have port src_sel, input, NREQ*SELW bits: requester i's wanted register select at bits [i*SELW +: SELW].
REQ-008 The block SHALL have port done, input, NREQ bits: owner releases the bus.
REQ-009 The block SHALL have port grant, output, NREQ bits: one-hot bus ownership, registered.
REQ-010 The block SHALL have port bus_sel, output, SELW bits: select driven to the bus mux, registered.
REQ-011 The block SHALL have port bus_valid, output, 1 bit: high while bus_sel belongs to a granted owner.
REQ-012 The block SHALL have port timeout, output, 1 bit: one-cycle pulse when an owner is forcibly released.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE (no owner) and OWN (one owner).
REQ-014 In IDLE, at an edge with any req bit high, the block SHALL pick a winner round-robin, starting the search at last_winner+1 mod NREQ, and enter OWN.
REQ-015 Grant latency SHALL be one cycle: req sampled at edge N gives grant, bus_sel and bus_valid valid after edge N.
REQ-016 On a grant, bus_sel SHALL latch the winner's src_sel slice; src_sel changes during ownership SHALL be ignored.
REQ-017 On a grant, the last_winner pointer SHALL update to the winner index.
REQ-018 In OWN, grant SHALL be exactly one-hot; in IDLE, grant SHALL be all zero, bus_valid 0 and bus_sel 0.
REQ-019 In OWN, a hold counter SHALL count cycles of ownership from 0; release occurs at the edge where owner done=1, owner req=0, or counter = MAX_HOLD-1.
REQ-020 At a release edge, the block SHALL arbitrate among req bits excluding the releasing owner; if any are set, the next owner SHALL be granted at that same edge (back-to-back, no idle bubble) and the counter SHALL reset to 0; otherwise the block SHALL go to IDLE.
REQ-021 A release caused only by the counter SHALL pulse timeout high for exactly the one cycle following that edge.
REQ-022 If done and counter expiry coincide, the release SHALL count as done and timeout SHALL stay 0.
REQ-023 done bits from non-owners SHALL be ignored.
REQ-024 With a single requester holding req high, the block SHALL re-grant it after a forced release only via IDLE, giving one cycle with bus_valid=0.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, grant=0, bus_sel=0, bus_valid=0, timeout=0, counter=0 and last_winner=NREQ-1, so requester 0 has first priority; this applies also mid-ownership.
REQ-026 After reset_n deasserts, the first arbitration SHALL occur at the first rising edge with reset_n high.

Structure
REQ-027 Shared package bus_arb_pkg SHALL hold the state encoding (IDLE, OWN) and the default NREQ/SELW/MAX_HOLD constants.
REQ-028 The combinational round-robin search SHALL be a sub-module rr_pick (inputs: request vector, start index; outputs: found flag, winner index).

Verification
REQ-029 Reset then req=0001, src_sel[0]=1 -> next cycle grant=0001, bus_sel=1, bus_valid=1; done[0] pulse -> IDLE, bus_valid=0.
REQ-030 req=0110 constant, src_sel[1]=7, src_sel[2]=19, owners assert done after 2 cycles -> grants alternate 0010, 0100, 0010... with bus_sel 7/19 and no bubble.
REQ-031 req=0001 held, never done, MAX_HOLD=8 -> grant lasts 8 cycles, timeout high 1 cycle, one cycle bus_valid=0, then re-grant.
REQ-032 Owner 0 changes src_sel[0] from 1 to 3 mid-ownership -> bus_sel stays 1 until release.
REQ-033 done[0] asserted on the 8th ownership cycle -> release without timeout pulse.
REQ-034 reset_n pulled low during ownership of requester 2 -> grant=0 and bus_valid=0 immediately; first grant after reset goes to lowest-index requesting bit.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared constants and FSM encoding for the bus arbiter.
// Imported by the arbiter top and its round-robin picker.
package bus_arb_pkg;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_SELW     = 5;
  localparam int DEF_MAX_HOLD = 8;
endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Combinational round-robin search: first set request at or after start.
// Wraps modulo NREQ; found is low when no request bit is set.
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   start_i,
  output logic            found_o,
  output logic [IW-1:0]   idx_o
);
  always_comb begin
    int k;
    found_o = 1'b0;
    idx_o   = '0;
    k       = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(start_i) + i) % NREQ;
      if (!found_o && req_i[k[IW-1:0]]) begin
        found_o = 1'b1;
        idx_o   = k[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with per-owner hold limit and timeout pulse.
// Back-to-back handover on release when another requester is waiting.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int SELW     = DEF_SELW,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SELW-1:0] src_sel,
  input  logic [NREQ-1:0]      done,
  output logic [NREQ-1:0]      grant,
  output logic [SELW-1:0]      bus_sel,
  output logic                 bus_valid,
  output logic                 timeout
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_HOLD) + 1;

  logic [0:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic            valid_q, valid_d;
  logic            tmo_q, tmo_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   last_q, last_d;

  logic [IW-1:0]   start, win;
  logic [NREQ-1:0] pick_req;
  logic            found;
  logic            own_done, own_req, cnt_exp, rel, arb;

  // The owner is always the last winner, so last_q doubles as owner index.
  assign own_done = done[last_q];
  assign own_req  = req[last_q];
  assign cnt_exp  = (cnt_q == CW'(MAX_HOLD - 1));
  assign rel      = (state_q == OWN) &&
                    (own_done || !own_req || cnt_exp);
  assign arb      = (state_q == IDLE) || rel;

  assign start = (last_q == IW'(NREQ - 1)) ? '0 : last_q + IW'(1);
  assign pick_req = (state_q == OWN) ?
                    (req & ~(NREQ'(1) << last_q)) : req;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (pick_req),
    .start_i (start),
    .found_o (found),
    .idx_o   (win)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    tmo_d   = 1'b0;
    cnt_d   = cnt_q;
    last_d  = last_q;
    unique case (1'b1)
      arb && found: begin
        state_d = OWN;
        grant_d = NREQ'(1) << win;
        sel_d   = src_sel[int'(win)*SELW +: SELW];
        valid_d = 1'b1;
        cnt_d   = '0;
        last_d  = win;
      end
      arb && !found: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
      default: cnt_d = cnt_q + CW'(1);
    endcase
    if (rel && cnt_exp && !own_done && own_req)
      tmo_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign grant     = grant_q;
  assign bus_sel   = sel_q;
  assign bus_valid = valid_q;
  assign timeout   = tmo_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of bus_arbiter against an owner/pointer model.
// Inputs change 1ns after each rising edge; outputs checked there too.
module tb_bus_arbiter;
  localparam int NREQ = 4;
  localparam int SELW = 5;
  localparam int MAXH = 8;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*SELW-1:0] src_sel;
  logic [NREQ-1:0]      done;
  logic [NREQ-1:0]      grant;
  logic [SELW-1:0]      bus_sel;
  logic                 bus_valid;
  logic                 timeout;

  int checks = 0;
  int errors = 0;

  int m_owner, m_last, m_cnt, m_sel;
  bit m_tmo;

  bus_arbiter #(.NREQ(NREQ), .SELW(SELW), .MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .src_sel   (src_sel),
    .done      (done),
    .grant     (grant),
    .bus_sel   (bus_sel),
    .bus_valid (bus_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_cnt   = 0;
    m_sel   = 0;
    m_tmo   = 1'b0;
  endfunction

  // One rising edge of the arbiter, from the rules in plain integers.
  function automatic void model_edge();
    bit go;
    int excl;
    int w;
    go   = 1'b0;
    excl = -1;
    w    = -1;
    m_tmo = 1'b0;
    if (m_owner < 0) begin
      go = 1'b1;
    end else if (done[m_owner] || !req[m_owner] || m_cnt == MAXH - 1) begin
      go    = 1'b1;
      excl  = m_owner;
      m_tmo = !done[m_owner] && req[m_owner];
    end
    if (!go) begin
      m_cnt++;
      return;
    end
    for (int i = 1; i <= NREQ; i++) begin
      int c;
      c = (m_last + i) % NREQ;
      if (w < 0 && req[c] && c != excl) w = c;
    end
    m_cnt = 0;
    if (w >= 0) begin
      m_owner = w;
      m_last  = w;
      m_sel   = int'(src_sel[w*SELW +: SELW]);
    end else begin
      m_owner = -1;
      m_sel   = 0;
    end
  endfunction

  task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check(string tag);
    logic [NREQ-1:0] eg;
    eg = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
    expect_eq({tag, ".grant"}, 32'(grant), 32'(eg));
    expect_eq({tag, ".sel"}, 32'(bus_sel), 32'(m_sel));
    expect_eq({tag, ".valid"}, 32'(bus_valid), 32'(m_owner >= 0));
    expect_eq({tag, ".tmo"}, 32'(timeout), 32'(m_tmo));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
  endtask

  // Asserted between edges: outputs must clear without waiting for clk.
  task automatic do_reset(string tag);
    reset_n = 1'b0;
    #2;
    model_reset();
    check({tag, ".async"});
    @(posedge clk);
    #1;
    check({tag, ".held"});
    reset_n = 1'b1;
  endtask

  task automatic set_sel(int i, int v);
    src_sel[i*SELW +: SELW] = SELW'(v);
  endtask

  initial begin
    int tcount;
    int vcount;
    reset_n = 1'b1;
    req     = '0;
    done    = '0;
    src_sel = '0;
    model_reset();
    #3;
    do_reset("rst0");

    // Simple grant then done release.
    req = 4'b0001;
    set_sel(0, 1);
    step("g0");
    expect_eq("g0.onehot", 32'(grant), 32'h1);
    expect_eq("g0.sel1", 32'(bus_sel), 32'd1);
    done = 4'b0001;
    req  = 4'b0000;
    step("g0.done");
    done = '0;
    expect_eq("g0.idle", 32'(bus_valid), 32'd0);
    step("idle");

    // Alternating owners, done after two cycles, no bubble.
    do_reset("rst1");
    req = 4'b0110;
    set_sel(1, 7);
    set_sel(2, 19);
    for (int c = 0; c < 12; c++) begin
      step("alt");
      done = (m_owner >= 0 && m_cnt == 1) ? NREQ'(1) << m_owner : '0;
      expect_eq("alt.nobubble", 32'(bus_valid), 32'd1);
    end
    done = '0;

    // Single requester held: forced release, one idle cycle, re-grant.
    do_reset("rst2");
    req = 4'b0001;
    set_sel(0, 1);
    tcount = 0;
    vcount = 0;
    for (int c = 0; c < 10; c++) begin
      step("hold");
      if (c == 0) set_sel(0, 3);
      tcount += int'(timeout);
      vcount += int'(bus_valid);
      if (c < 8) expect_eq("hold.sel", 32'(bus_sel), 32'd1);
    end
    expect_eq("hold.tmo_count", 32'(tcount), 32'd1);
    expect_eq("hold.valid_count", 32'(vcount), 32'd9);

    // done on the eighth ownership cycle: no timeout pulse.
    do_reset("rst3");
    req = 4'b0001;
    for (int c = 0; c < 10; c++) begin
      step("dx");
      done = (m_owner == 0 && m_cnt == MAXH - 1) ? 4'b0001 : 4'b0000;
      expect_eq("dx.notmo", 32'(timeout), 32'd0);
    end
    done = '0;

    // Reset while requester 2 owns the bus.
    do_reset("rst4");
    req = 4'b0100;
    step("r2");
    expect_eq("r2.owner", 32'(grant), 32'h4);
    step("r2b");
    req = 4'b1110;
    do_reset("rst5");
    step("r2.after");
    expect_eq("r2.lowest", 32'(grant), 32'h2);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      req  = NREQ'($urandom);
      done = ($urandom_range(0, 3) == 0) ? NREQ'($urandom) : '0;
      for (int i = 0; i < NREQ; i++) set_sel(i, $urandom_range(0, 31));
      if ($urandom_range(0, 99) == 0) do_reset("rnd.rst");
      else step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
